hex_scan_mux: RTL and testbench



---
 rtl/hex_scan_mux.sv | 67 ++++++
 tb/tb_hex_scan_mux.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/hex_scan_mux.sv
// hex_scan_mux: time-multiplexed hex digit scanner feeding a 7-segment decoder (common anode).
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits above digit 0.
module hex_scan_mux #(
    parameter int DIGITS = 4,
    parameter int DIV    = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    output logic [3:0]            nibble,
    output logic [DIGITS-1:0]     an,
    output logic                  digit_tick
);
    localparam int CW = $clog2(DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    generate
        if (DIGITS < 1 || DIGITS > 8 || DIV < 2) begin : g_bad_params
            $error("hex_scan_mux: DIGITS must be 1..8 and DIV >= 2");
        end
    endgenerate

    logic [4*DIGITS-1:0] shadow_q, shadow_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic                wrap, lit;

    always_comb begin
        wrap     = cnt_q == CW'(DIV - 1);
        shadow_d = load ? value : shadow_q;
        cnt_d    = wrap ? '0 : cnt_q + CW'(1);
        idx_d    = !wrap ? idx_q : (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] blank;

    // A digit is blank when it and every digit above it are zero; digit 0 always shows.
    always_comb begin
        blank = '0;
        for (int k = 1; k < DIGITS; k++) blank[k] = (shadow_q >> (4 * k)) == '0;
    end

    always_comb lit = (cnt_q != '0) && !(1'(blank >> idx_q));
`else
    always_comb lit = cnt_q != '0;
`endif

    always_comb begin
        nibble     = 4'(shadow_q >> {idx_q, 2'b00});
        digit_tick = wrap;
        an         = lit ? ~(DIGITS'(1) << idx_q) : '1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
        end else begin
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
        end
    end
endmodule

// File: tb/tb_hex_scan_mux.sv
// tb_hex_scan_mux: randomized and directed checks of hex_scan_mux (DIGITS=4, DIV=4) against a time-based model.
module tb_hex_scan_mux;
    logic        clk = 1'b0, clk_en = 1'b0, rst = 1'b0, load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  nibble, an;
    logic        digit_tick;
    int          total = 0, bad = 0;
    int          m_t = 0;
    logic [15:0] m_sh = '0;

    hex_scan_mux #(.DIGITS(4), .DIV(4)) dut (
        .clk(clk), .rst(rst), .load(load), .value(value),
        .nibble(nibble), .an(an), .digit_tick(digit_tick)
    );

    always #5 clk = clk_en ? ~clk : 1'b0;

    // Model: m_t counts edges since reset release; slot and phase follow from plain division.
    function automatic logic [3:0] exp_an(int t, logic [15:0] sh);
        int slot = (t / 4) % 4;
        if (t % 4 == 0) return 4'hF;
`ifdef LEADING_ZERO_BLANK_EN
        if (slot > 0 && (sh >> (4 * slot)) == 16'h0) return 4'hF;
`endif
        return ~(4'b0001 << slot);
    endfunction

    function automatic logic [3:0] exp_nib(int t, logic [15:0] sh);
        logic [15:0] s = sh >> (4 * ((t / 4) % 4));
        return s[3:0];
    endfunction

    function automatic logic exp_tick(int t);
        return t % 4 == 3;
    endfunction

    task automatic step(input logic ld, input logic [15:0] v);
        load = ld;
        value = v;
        @(posedge clk);
        if (ld) m_sh = v;
        m_t++;
        #1 load = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #1;
        total++; if (an !== 4'hF) begin bad++; $display("FAIL reset_an got=%b want=1111", an); end
        total++; if (nibble !== 4'h0) begin bad++; $display("FAIL reset_nibble got=%h want=0", nibble); end
        total++; if (digit_tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b want=0", digit_tick); end
        rst = 1'b0;
        m_t = 0;
        m_sh = '0;
        clk_en = 1'b1;
        #1;
        total++; if (an !== 4'hF) begin bad++; $display("FAIL release_guard_an got=%b want=1111", an); end
    endtask

    task automatic test_scan;
        step(1'b1, 16'h1A2F);
        total++; if (an !== 4'b1110 || nibble !== 4'hF) begin bad++; $display("FAIL scan_first got an=%b nib=%h want an=1110 nib=f", an, nibble); end
        for (int i = 0; i < 19; i++) begin
            step(1'b0, 16'h0);
            total++; if (an !== exp_an(m_t, m_sh)) begin bad++; $display("FAIL scan_an t=%0d got=%b want=%b", m_t, an, exp_an(m_t, m_sh)); end
            total++; if (nibble !== exp_nib(m_t, m_sh)) begin bad++; $display("FAIL scan_nib t=%0d got=%h want=%h", m_t, nibble, exp_nib(m_t, m_sh)); end
            total++; if (digit_tick !== exp_tick(m_t)) begin bad++; $display("FAIL scan_tick t=%0d got=%b want=%b", m_t, digit_tick, exp_tick(m_t)); end
        end
    endtask

    task automatic test_ticks;
        int n = 0, last = -1;
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 16'h0);
            total++; if (digit_tick !== exp_tick(m_t)) begin bad++; $display("FAIL tick_pos t=%0d got=%b want=%b", m_t, digit_tick, exp_tick(m_t)); end
            if (digit_tick === 1'b1) begin
                if (last >= 0) begin
                    total++; if (m_t - last !== 4) begin bad++; $display("FAIL tick_spacing got=%0d want=4", m_t - last); end
                end
                last = m_t;
                n++;
            end
        end
        total++; if (n !== 8) begin bad++; $display("FAIL tick_count got=%0d want=8", n); end
    endtask

    task automatic test_midload;
        while (m_t % 16 != 6) step(1'b0, 16'h0);
        step(1'b1, 16'h1A2F);
        while (m_t % 16 != 6) step(1'b0, 16'h0);
        total++; if (nibble !== 4'h2 || an !== 4'b1101) begin bad++; $display("FAIL midload_before got an=%b nib=%h want an=1101 nib=2", an, nibble); end
        step(1'b1, 16'h00C0);
        total++; if (nibble !== 4'hC) begin bad++; $display("FAIL midload_nib got=%h want=c", nibble); end
        total++; if (an !== 4'b1101) begin bad++; $display("FAIL midload_an got=%b want=1101", an); end
        total++; if (digit_tick !== 1'b1) begin bad++; $display("FAIL midload_tick got=%b want=1", digit_tick); end
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 16'h0);
            total++; if (an !== exp_an(m_t, m_sh)) begin bad++; $display("FAIL midload_an_after t=%0d got=%b want=%b", m_t, an, exp_an(m_t, m_sh)); end
            total++; if (nibble !== exp_nib(m_t, m_sh)) begin bad++; $display("FAIL midload_nib_after t=%0d got=%h want=%h", m_t, nibble, exp_nib(m_t, m_sh)); end
        end
    endtask

    task automatic test_async_reset;
        step(1'b1, 16'h1A2F);
        while (m_t % 16 != 10) step(1'b0, 16'h0);
        #2 rst = 1'b1;
        #1;
        total++; if (an !== 4'hF) begin bad++; $display("FAIL areset_an got=%b want=1111", an); end
        total++; if (nibble !== 4'h0) begin bad++; $display("FAIL areset_nib got=%h want=0", nibble); end
        @(negedge clk);
        rst = 1'b0;
        m_t = 0;
        m_sh = '0;
        #1;
        total++; if (an !== 4'hF) begin bad++; $display("FAIL areset_guard got=%b want=1111", an); end
        step(1'b1, 16'h1A2F);
        total++; if (an !== 4'b1110 || nibble !== 4'hF) begin bad++; $display("FAIL areset_slot0 got an=%b nib=%h want an=1110 nib=f", an, nibble); end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 16'h0);
            total++; if (an !== exp_an(m_t, m_sh)) begin bad++; $display("FAIL areset_an_after t=%0d got=%b want=%b", m_t, an, exp_an(m_t, m_sh)); end
            total++; if (nibble !== exp_nib(m_t, m_sh)) begin bad++; $display("FAIL areset_nib_after t=%0d got=%h want=%h", m_t, nibble, exp_nib(m_t, m_sh)); end
        end
    endtask

    task automatic test_blank;
        logic [15:0] vals [2] = '{16'h0005, 16'h0000};
        for (int j = 0; j < 2; j++) begin
            step(1'b1, vals[j]);
            for (int i = 0; i < 16; i++) begin
                step(1'b0, 16'h0);
                total++; if (an !== exp_an(m_t, m_sh)) begin bad++; $display("FAIL blank_an v=%h t=%0d got=%b want=%b", m_sh, m_t, an, exp_an(m_t, m_sh)); end
                total++; if (nibble !== exp_nib(m_t, m_sh)) begin bad++; $display("FAIL blank_nib v=%h t=%0d got=%h want=%h", m_sh, m_t, nibble, exp_nib(m_t, m_sh)); end
            end
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 3) == 0, 16'($urandom));
            total++; if (an !== exp_an(m_t, m_sh)) begin bad++; $display("FAIL rand_an t=%0d got=%b want=%b", m_t, an, exp_an(m_t, m_sh)); end
            total++; if (nibble !== exp_nib(m_t, m_sh)) begin bad++; $display("FAIL rand_nib t=%0d got=%h want=%h", m_t, nibble, exp_nib(m_t, m_sh)); end
            total++; if (digit_tick !== exp_tick(m_t)) begin bad++; $display("FAIL rand_tick t=%0d got=%b want=%b", m_t, digit_tick, exp_tick(m_t)); end
        end
    endtask

    initial begin
        test_reset;
        test_scan;
        test_ticks;
        test_midload;
        test_async_reset;
        test_blank;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
